// File: rtl/vx_ifetch_rsp_queue_pkg.sv
// Shared widths and the buffered instruction-fetch response record.
package VX_fetch_pkg;
  localparam int UUID_BITS   = 16;
  localparam int NUM_THREADS = 4;
  localparam int NW_BITS     = 3;

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [NW_BITS-1:0]     wid;
    logic [31:0]            PC;
    logic [31:0]            data;
  } ifetch_rsp_entry_t;
endpackage

// File: rtl/vx_ifetch_rsp_queue_if.sv
// Instruction-fetch response channel: valid/ready handshake plus payload.
interface VX_ifetch_rsp_if;
  import VX_fetch_pkg::*;

  logic                   valid;
  logic [UUID_BITS-1:0]   uuid;
  logic [NUM_THREADS-1:0] tmask;
  logic [NW_BITS-1:0]     wid;
  logic [31:0]            PC;
  logic [31:0]            data;
  logic                   ready;

  modport master (output valid, uuid, tmask, wid, PC, data, input ready);
  modport slave  (input valid, uuid, tmask, wid, PC, data, output ready);
endinterface

// File: rtl/vx_ifetch_rsp_queue_store.sv
// Entry storage with combinational head read and per-slot kill bits set by warp id.
module VX_ifetch_rsp_store
  import VX_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_idx,
  input  ifetch_rsp_entry_t wr_data,
  input  logic [PTR_W-1:0]  rd_idx,
  output ifetch_rsp_entry_t rd_data,
  output logic              rd_kill,
  input  logic              kill_en,
  input  logic [NW_BITS-1:0] kill_wid,
  input  logic [DEPTH-1:0]  kill_mask
);
  ifetch_rsp_entry_t mem_q [DEPTH];
  logic [DEPTH-1:0]  kill_q;
  logic [DEPTH-1:0]  kill_d;

  // Payload is intentionally left unreset; only the kill bits carry state meaning.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
    // A fresh write always lands live, overriding any flush aimed at the old occupant.
    assign kill_d[gi] = !(wr_en && (wr_idx == PTR_W'(gi))) &&
                        (kill_q[gi] || (kill_en && kill_mask[gi] && (mem_q[gi].wid == kill_wid)));
  end

  always_ff @(posedge clk) begin
    if (reset) kill_q <= '0;
    else       kill_q <= kill_d;
  end

  assign rd_data = mem_q[rd_idx];
  assign rd_kill = kill_q[rd_idx];
endmodule

// File: rtl/vx_ifetch_rsp_queue.sv
// In-order response queue between icache and decode with per-warp flush of buffered entries.
module vx_ifetch_rsp_queue
  import VX_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  VX_ifetch_rsp_if.slave     ifetch_rsp_in,
  VX_ifetch_rsp_if.master    ifetch_rsp_out,
  input  logic               flush_valid,
  input  logic [NW_BITS-1:0] flush_wid,
  output logic [CNT_W-1:0]   count
);
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  ifetch_rsp_entry_t wr_entry, head_entry;
  logic              head_kill, not_empty, in_hs, push_wr, pop, drop, retire;
  logic [DEPTH-1:0]  occ_mask;

  assign not_empty           = (count_q != '0);
  assign ifetch_rsp_in.ready = !reset && (count_q < CNT_W'(DEPTH));
  assign in_hs               = ifetch_rsp_in.valid && ifetch_rsp_in.ready;
  // A response whose warp is being flushed this cycle is swallowed, never stored.
  assign push_wr             = in_hs && !(flush_valid && (flush_wid == ifetch_rsp_in.wid));

  assign ifetch_rsp_out.valid = !reset && not_empty && !head_kill;
  assign pop                  = ifetch_rsp_out.valid && ifetch_rsp_out.ready;
  assign drop                 = not_empty && head_kill;
  assign retire               = pop || drop;

  assign wr_entry = '{uuid:  ifetch_rsp_in.uuid,  tmask: ifetch_rsp_in.tmask,
                      wid:   ifetch_rsp_in.wid,   PC:    ifetch_rsp_in.PC,
                      data:  ifetch_rsp_in.data};

  assign ifetch_rsp_out.uuid  = head_entry.uuid;
  assign ifetch_rsp_out.tmask = head_entry.tmask;
  assign ifetch_rsp_out.wid   = head_entry.wid;
  assign ifetch_rsp_out.PC    = head_entry.PC;
  assign ifetch_rsp_out.data  = head_entry.data;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
    logic [PTR_W-1:0] offset;
    assign offset       = PTR_W'(gi) - rd_ptr_q;
    assign occ_mask[gi] = ({1'b0, offset} < count_q);
  end

  VX_ifetch_rsp_store #(.DEPTH(DEPTH)) u_store (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (push_wr),
    .wr_idx    (wr_ptr_q),
    .wr_data   (wr_entry),
    .rd_idx    (rd_ptr_q),
    .rd_data   (head_entry),
    .rd_kill   (head_kill),
    .kill_en   (flush_valid),
    .kill_wid  (flush_wid),
    .kill_mask (occ_mask)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (retire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push_wr, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: tb/tb_vx_ifetch_rsp_queue.sv
// Bench for vx_ifetch_rsp_queue: directed vector table, streaming run, then random traffic vs a queue model.
module tb_vx_ifetch_rsp_queue;
  import VX_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_valid;
  logic [2:0] flush_wid;
  logic [2:0] count;
  logic [15:0] uu_cnt = 16'd0;

  int n_err = 0;
  int n_chk = 0;

  VX_ifetch_rsp_if in_if ();
  VX_ifetch_rsp_if out_if ();

  vx_ifetch_rsp_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (rst),
    .ifetch_rsp_in  (in_if),
    .ifetch_rsp_out (out_if),
    .flush_valid    (flush_valid),
    .flush_wid      (flush_wid),
    .count          (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    ifetch_rsp_entry_t e;
    bit                killed;
  } mentry_t;
  mentry_t mq[$];

  typedef struct {
    logic        r;
    logic        iv;
    logic [2:0]  w;
    logic [31:0] pc;
    logic [31:0] d;
    logic        ordy;
    logic        fv;
    logic [2:0]  fw;
    int          ecnt;
    logic        erdy;
    logic        eov;
    logic [31:0] epc;
  } vec_t;
  vec_t vq[$];

  task automatic v(input logic r, input logic iv, input logic [2:0] w, input logic [31:0] pc,
                   input logic [31:0] d, input logic ordy, input logic fv, input logic [2:0] fw,
                   input int ecnt, input logic erdy, input logic eov, input logic [31:0] epc);
    vec_t t;
    t.r = r; t.iv = iv; t.w = w; t.pc = pc; t.d = d; t.ordy = ordy; t.fv = fv; t.fw = fw;
    t.ecnt = ecnt; t.erdy = erdy; t.eov = eov; t.epc = epc;
    vq.push_back(t);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [2:0] w, input logic [31:0] pc,
                       input logic [31:0] d, input logic ordy, input logic fv, input logic [2:0] fw);
    rst          = r;
    in_if.valid  = iv;
    in_if.wid    = w;
    in_if.PC     = pc;
    in_if.data   = d;
    in_if.uuid   = uu_cnt;
    in_if.tmask  = uu_cnt[3:0];
    uu_cnt       = uu_cnt + 16'd1;
    out_if.ready = ordy;
    flush_valid  = fv;
    flush_wid    = fw;
  endtask

  // Reference behaviour at a clock edge: retire head, mark flushed warp, then append.
  task automatic model_update();
    bit hs;
    mentry_t ne;
    if (rst) begin
      mq.delete();
    end else begin
      hs = in_if.valid && (mq.size() < DEPTH);
      if (mq.size() != 0) begin
        if (mq[0].killed || out_if.ready) void'(mq.pop_front());
      end
      if (flush_valid) begin
        foreach (mq[i]) if (mq[i].e.wid == flush_wid) mq[i].killed = 1'b1;
      end
      if (hs && !(flush_valid && (in_if.wid == flush_wid))) begin
        ne.e = '{uuid: in_if.uuid, tmask: in_if.tmask, wid: in_if.wid, PC: in_if.PC, data: in_if.data};
        ne.killed = 1'b0;
        mq.push_back(ne);
      end
    end
  endtask

  task automatic cycle();
    logic er, ev;
    ifetch_rsp_entry_t act;
    #1;
    er = !rst && (mq.size() < DEPTH);
    ev = !rst && (mq.size() != 0) && !mq[0].killed;
    check("count", 128'(count), 128'(mq.size()));
    check("in_ready", 128'(in_if.ready), 128'(er));
    check("out_valid", 128'(out_if.valid), 128'(ev));
    if (ev) begin
      act = '{uuid: out_if.uuid, tmask: out_if.tmask, wid: out_if.wid, PC: out_if.PC, data: out_if.data};
      check("payload", 128'(act), 128'(mq[0].e));
      if (out_if.ready)
        $display("out: wid=%0d pc=%08h data=%08h uuid=%0h", act.wid, act.PC, act.data, act.uuid);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    // fill and backpressure
    v(0,1,0,32'h00,32'h01,0,0,0, 0,1,0,32'h00);
    v(0,1,0,32'h04,32'h05,0,0,0, 1,1,1,32'h00);
    v(0,1,0,32'h08,32'h09,0,0,0, 2,1,1,32'h00);
    v(0,1,0,32'h0C,32'h0D,0,0,0, 3,1,1,32'h00);
    v(0,1,0,32'h10,32'h11,0,0,0, 4,0,1,32'h00);
    v(0,1,0,32'h10,32'h11,1,0,0, 4,0,1,32'h00);
    v(0,1,0,32'h10,32'h11,1,0,0, 3,1,1,32'h04);
    v(0,0,0,32'h00,32'h00,1,0,0, 3,1,1,32'h08);
    v(0,0,0,32'h00,32'h00,1,0,0, 2,1,1,32'h0C);
    v(0,0,0,32'h00,32'h00,1,0,0, 1,1,1,32'h10);
    v(0,0,0,32'h00,32'h00,1,0,0, 0,1,0,32'h00);
    // flush mid-queue, wids {1,0,1,3}
    v(0,1,1,32'h100,32'h101,0,0,0, 0,1,0,32'h000);
    v(0,1,0,32'h104,32'h105,0,0,0, 1,1,1,32'h100);
    v(0,1,1,32'h108,32'h109,0,0,0, 2,1,1,32'h100);
    v(0,1,3,32'h10C,32'h10D,0,0,0, 3,1,1,32'h100);
    v(0,0,0,32'h000,32'h000,0,1,1, 4,0,1,32'h100);
    v(0,0,0,32'h000,32'h000,1,0,0, 4,0,0,32'h000);
    v(0,0,0,32'h000,32'h000,1,0,0, 3,1,1,32'h104);
    v(0,0,0,32'h000,32'h000,1,0,0, 2,1,0,32'h000);
    v(0,0,0,32'h000,32'h000,1,0,0, 1,1,1,32'h10C);
    v(0,0,0,32'h000,32'h000,1,0,0, 0,1,0,32'h000);
    // flush colliding with push
    v(0,1,5,32'h200,32'h201,1,1,5, 0,1,0,32'h000);
    v(0,0,0,32'h000,32'h000,1,0,0, 0,1,0,32'h000);
    // reset mid-operation
    v(0,1,2,32'h300,32'h301,0,0,0, 0,1,0,32'h000);
    v(0,1,2,32'h304,32'h305,0,0,0, 1,1,1,32'h300);
    v(0,1,2,32'h308,32'h309,0,0,0, 2,1,1,32'h300);
    v(1,0,0,32'h000,32'h000,0,0,0, 3,0,0,32'h000);
    v(0,0,0,32'h000,32'h000,1,0,0, 0,1,0,32'h000);
    v(0,0,0,32'h000,32'h000,1,0,0, 0,1,0,32'h000);
    // single response
    v(0,1,2,32'h8000_0000,32'h0000_0013,1,0,0, 0,1,0,32'h0);
    v(0,0,0,32'h0,32'h0,1,0,0, 1,1,1,32'h8000_0000);
    v(0,0,0,32'h0,32'h0,1,0,0, 0,1,0,32'h0);
    // flush of a stalled head warp
    v(0,1,4,32'h400,32'h401,0,0,0, 0,1,0,32'h000);
    v(0,0,0,32'h000,32'h000,0,1,4, 1,1,1,32'h400);
    v(0,0,0,32'h000,32'h000,0,0,0, 1,1,0,32'h000);
    v(0,0,0,32'h000,32'h000,0,0,0, 0,1,0,32'h000);

    drive(1,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].r, vq[i].iv, vq[i].w, vq[i].pc, vq[i].d, vq[i].ordy, vq[i].fv, vq[i].fw);
      #1;
      $display("vec %0d: count=%0d in_ready=%0b out_valid=%0b pc=%08h", i, count, in_if.ready,
               out_if.valid, out_if.PC);
      check($sformatf("vec%0d_count", i), 128'(count), 128'(vq[i].ecnt));
      check($sformatf("vec%0d_in_ready", i), 128'(in_if.ready), 128'(vq[i].erdy));
      check($sformatf("vec%0d_out_valid", i), 128'(out_if.valid), 128'(vq[i].eov));
      if (vq[i].eov) check($sformatf("vec%0d_pc", i), 128'(out_if.PC), 128'(vq[i].epc));
      cycle();
    end

    // streaming: one in, one out per cycle across several pointer wraps
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 3'(k % 8), 32'h500 + 32'(4 * k), 32'(k) ^ 32'hA5A5_0000, 1, 0, 0);
      if (k > 0) check("stream_count", 128'(count), 128'(1));
      cycle();
    end
    drive(0,0,0,0,0,1,0,0);
    cycle();

    for (int k = 0; k < 600; k++) begin
      drive(($urandom % 64) == 0, ($urandom % 4) != 0, 3'($urandom % 4), $urandom, $urandom,
            ($urandom % 10) < 6, ($urandom % 8) == 0, 3'($urandom % 4));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vx_ifetch_rsp_queue.md
# VX_ifetch_rsp_queue

Receiving end of the instruction-fetch response channel. The block accepts responses from the icache stage through a `VX_ifetch_rsp_if` slave port and buffers them in a `DEPTH`-entry in-order queue. It re-presents them to decode through a `VX_ifetch_rsp_if` master port. A per-warp flush drops buffered responses of a redirected warp so that decode never sees stale instructions.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ifetch_rsp_in.valid`  in  1  response valid from icache.
- `ifetch_rsp_in.uuid`  in  `UUID_BITS`  instruction uuid.
- `ifetch_rsp_in.tmask`  in  `NUM_THREADS`  thread mask.
- `ifetch_rsp_in.wid`  in  `NW_BITS`  warp id.
- `ifetch_rsp_in.PC`  in  32  fetch PC.
- `ifetch_rsp_in.data`  in  32  instruction word.
- `ifetch_rsp_in.ready`  out  1  queue can accept.
- `ifetch_rsp_out.valid`, `.uuid`, `.tmask`, `.wid`, `.PC`, `.data`  out  (same widths as input)  head entry to decode.
- `ifetch_rsp_out.ready`  in  1  decode accepts.
- `flush_valid`  in  1  kill request.
- `flush_wid`  in  `NW_BITS`  warp to kill.
- `count`  out  `$clog2(DEPTH)+1`  occupied slots, killed entries included.

## Operation
Storage:
- Circular array of `DEPTH` entries, each holding {uuid, tmask, wid, PC, data} plus a `kill` bit.
- Read pointer `rd_ptr` and write pointer `wr_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`.
- `count` register tracks occupancy.

Input handshake and push:
- `in.ready = !reset && (count < DEPTH)`.
- No pass-through when full, even if the head pops in the same cycle.
- Push occurs on `in.valid && in.ready`: write the slot at `wr_ptr` with `kill = 0`, then advance `wr_ptr`.
- If `flush_valid && flush_wid == in.wid` in the push cycle, the response is accepted (handshake completes) but discarded. Nothing is written and `wr_ptr` and `count` do not advance.

Output and pop:
- `out.valid = (count != 0) && !kill[rd_ptr]`.
- Payload is driven combinationally from the head slot.
- Pop occurs on `out.valid && out.ready`.
- Drop occurs when `count != 0 && kill[rd_ptr]`: the head is popped with no output, one killed entry per cycle.

Flush:
- On `flush_valid`, set `kill` on every occupied slot whose `wid == flush_wid`.
- This is applied after the current cycle's pop or drop. An entry handshaken in the flush cycle is delivered.
- Flush never changes `count` directly. Killed entries drain through the drop path.

Count update per cycle: `count += push_written - (pop | drop)`. Push and pop in the same cycle leave `count` unchanged.

Ordering: responses leave in acceptance order. A killed entry never appears on the output.

## Timing
- Minimum latency: 1 cycle. An input accepted at edge N is visible on `out` in the cycle after edge N.
- Output stability: while `out.valid && !out.ready`, the payload holds. The exception is a flush of the head warp: `out.valid` deasserts the cycle after the flush cycle.
- Reset (synchronous, asserted at any time, including mid-stream):
  - `rd_ptr = wr_ptr = count = 0` and all `kill = 0`.
  - `out.valid = 0` and `in.ready = 0` while `reset` is high.
  - `in.ready = 1` in the first cycle after deassertion.
  - Buffered entries are lost. Payload registers are not reset.
- Full (`count == DEPTH`): `in.ready = 0`. It rises the cycle after a pop or drop.
- Empty: `out.valid = 0`. The payload value is don't-care.
- Wrap: pointers wrap from `DEPTH-1` to 0 with no bubble.

## Structure
- Package `VX_fetch_pkg` holds `ifetch_rsp_entry_t`, a packed struct of uuid, tmask, wid, PC and data.
- Optional sub-module `VX_ifetch_rsp_store`: entry array plus per-slot `kill` vector, with write port, head read port and a wid-match kill port.
- Pointer and count logic stays in the top module.

## Test plan
- Single response: push {wid=2, PC=0x8000_0000, data=0x0000_0013}, out.ready=1 → out.valid one cycle later with identical fields; count goes 1→0.
- Fill and backpressure, DEPTH=4: 5 back-to-back valids, out.ready=0 → in.ready drops after 4 accepts and count=4. Raise out.ready → entries PC 0x00,0x04,0x08,0x0C emerge in order; the 5th is accepted the cycle after the first pop.
- Streaming: continuous valid and ready for 20 cycles → one output per cycle, count stays 1, and pointers wrap without loss.
- Flush mid-queue: queue holds wids {1,0,1,3}; flush wid=1 → outputs are only wid 0 then wid 3; count drains 4→0 over 4 cycles.
- Flush with colliding push: in.valid with wid=5 and flush_wid=5 in the same cycle → in.ready=1, count unchanged, nothing emitted.
- Reset mid-operation: count=3, assert reset for 1 cycle → out.valid=0 and in.ready=0 during reset; the next cycle has count=0 and in.ready=1, and the old entries never appear.
